exe_stage_unit: RTL and testbench
=================================

EXE_STAGE_UNIT -- requirements
Module: exe_stage_unit

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed.
REQ-002 SHALL use this port order:
- clk  in  1  clock.
- reset_n  in  1  async active-low reset.
- ForwardA, ForwardB  in  2 each  operand forward selects.
- ALUresult_EXE_MEM, ALUresult_MEM_WB  in  32 each  forwarded results.
- readData1, readData2  in  32 each  register operands.
- imm  in  32  immediate.
- RegDestination  in  5  destination register.
- pc  in  32  instruction PC.
- MemtoReg  in  2  WB select.
- ALUOp  in  4  ALU operation.
- WordOrByte, MemRead, MemWrite  in  1 each  MEM controls.
- ALUSrc  in  1  0=readData2, 1=imm.
- RegWrite  in  1  WB write enable.
- ALUresult  out  32  ALU result.
- pc_MEM  out  32  PC pass-through.
- WriteData_MEM  out  32  store data.
- RegDestination_MEM  out  5  destination pass-through.
- MemtoReg_MEM  out  2  pass-through.
- WordOrByte_MEM, MemRead_MEM, MemWrite_MEM, RegWrite_MEM  out  1 each  pass-throughs.
REQ-003 SHALL be built from submodules ALU, MUX2x1 (32-bit, sel 0 -> in0) and MUX4x1 (32-bit, sel 00..11 -> in0..in3).

Function
REQ-004 SHALL be purely combinational; clk and reset_n SHALL be present but SHALL NOT affect any output, so outputs follow inputs in the same cycle (zero latency).
REQ-005 SHALL form ALUOperand2 = ALUSrc ? imm : readData2.
REQ-006 SHALL form OpA by ForwardA: 00 readData1, 01 ALUresult_EXE_MEM, 10 ALUresult_MEM_WB, 11 zero.
REQ-007 SHALL form OpB by ForwardB: 00 ALUOperand2, 01 ALUresult_EXE_MEM, 10 ALUresult_MEM_WB, 11 zero; forwarding overrides the immediate.
REQ-008 SHALL compute ALUresult = f(OpA, OpB) by ALUOp: 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 SLL; 0101 SRL; 0110 SUB (OpA-OpB); 0111 SLT signed; 1000 SRA; 1001 SLTU; all other codes -> 0.
REQ-009 SHALL wrap ADD/SUB modulo 2^32 with no overflow output.
REQ-010 SHALL take shift amount from OpB[4:0]; SLT/SLTU SHALL yield 32'd1 or 32'd0.
REQ-011 SHALL have ALU produce an internal zero flag (ALUresult==0), left unconnected at the top level.
REQ-012 SHALL drive WriteData_MEM = readData2 (unforwarded, independent of ALUSrc).
REQ-013 SHALL pass pc, RegDestination, MemtoReg, RegWrite, WordOrByte, MemRead and MemWrite unchanged to the *_MEM outputs.

Reset
REQ-014 SHALL hold no state; during and after reset_n=0 every output SHALL still equal its combinational function of the current inputs.

Verification
REQ-015 reset_n=0, readData1=50, readData2=20, imm=16, ALUSrc=1, ALUOp=0110, Forward=00/00, pc=8, RegDestination=2, MemtoReg=01, WordOrByte=1, MemRead=1, MemWrite=0, RegWrite=1 -> ALUresult=34, WriteData_MEM=20, pc_MEM=8, control outputs mirror inputs.
REQ-016 ALUSrc=0, ALUOp=0010, readData1=50, readData2=20 -> ALUresult=70; ALUOp=0110, readData1=16, readData2=20 -> 0xFFFFFFFC.
REQ-017 ForwardA=01, ALUresult_EXE_MEM=100, ForwardB=10, ALUresult_MEM_WB=7, ALUOp=0010, ALUSrc=1, imm=16 -> ALUresult=107.
REQ-018 ForwardB=11, ALUOp=0001, readData1=0x0F -> ALUresult=0x0F; ForwardA=11, ALUOp=0010 -> OpA is 0, so ALUresult=OpB.
REQ-019 OpA=0xFFFFFFFF, OpB=1: ALUOp=0111 -> 1, ALUOp=1001 -> 0; OpA=0x80000000, OpB=4: ALUOp=1000 -> 0xF8000000, ALUOp=0101 -> 0x08000000; ALUOp=1111 -> 0.
REQ-020 toggle clk and reset_n with data inputs constant -> no output changes.

Source files
------------

// File: rtl/exe_stage_unit.sv
// Execute stage: operand forwarding, immediate select, ALU, and MEM-stage pass-throughs.
// Purely combinational; clk and reset_n are carried for pipeline wiring only.

module MUX2x1 (
    input  logic [31:0] i_in0,
    input  logic [31:0] i_in1,
    input  logic        i_sel,
    output logic [31:0] o_out
);
    assign o_out = i_sel ? i_in1 : i_in0;
endmodule

module MUX4x1 (
    input  logic [31:0] i_in0,
    input  logic [31:0] i_in1,
    input  logic [31:0] i_in2,
    input  logic [31:0] i_in3,
    input  logic [1:0]  i_sel,
    output logic [31:0] o_out
);
    always_comb begin
        o_out = i_in0;
        case (i_sel)
            2'b00: o_out = i_in0;
            2'b01: o_out = i_in1;
            2'b10: o_out = i_in2;
            2'b11: o_out = i_in3;
            default: o_out = i_in0;
        endcase
    end
endmodule

module ALU (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_op,
    output logic [31:0] o_result,
    output logic        o_zero
);
    logic [4:0] w_shamt;
    assign w_shamt = i_b[4:0];

    always_comb begin
        o_result = 32'd0;
        case (i_op)
            4'b0000: o_result = i_a & i_b;
            4'b0001: o_result = i_a | i_b;
            4'b0010: o_result = i_a + i_b;
            4'b0011: o_result = i_a ^ i_b;
            4'b0100: o_result = i_a << w_shamt;
            4'b0101: o_result = i_a >> w_shamt;
            4'b0110: o_result = i_a - i_b;
            4'b0111: o_result = ($signed(i_a) < $signed(i_b)) ? 32'd1 : 32'd0;
            4'b1000: o_result = $unsigned($signed(i_a) >>> w_shamt);
            4'b1001: o_result = (i_a < i_b) ? 32'd1 : 32'd0;
            default: o_result = 32'd0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);
endmodule

module exe_stage_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [31:0] ALUresult_EXE_MEM,
    input  logic [31:0] ALUresult_MEM_WB,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    input  logic [31:0] imm,
    input  logic [4:0]  RegDestination,
    input  logic [31:0] pc,
    input  logic [1:0]  MemtoReg,
    input  logic [3:0]  ALUOp,
    input  logic        WordOrByte,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        ALUSrc,
    input  logic        RegWrite,
    output logic [31:0] ALUresult,
    output logic [31:0] pc_MEM,
    output logic [31:0] WriteData_MEM,
    output logic [4:0]  RegDestination_MEM,
    output logic [1:0]  MemtoReg_MEM,
    output logic        WordOrByte_MEM,
    output logic        MemRead_MEM,
    output logic        MemWrite_MEM,
    output logic        RegWrite_MEM
);
    logic [31:0] w_operand2;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic        w_zero_unused;
    logic        w_clk_rst_unused;

    // No state lives here, so the clock and reset are intentionally left dangling.
    assign w_clk_rst_unused = clk & reset_n;

    MUX2x1 u_src_mux (
        .i_in0 (readData2),
        .i_in1 (imm),
        .i_sel (ALUSrc),
        .o_out (w_operand2)
    );

    MUX4x1 u_fwd_a (
        .i_in0 (readData1),
        .i_in1 (ALUresult_EXE_MEM),
        .i_in2 (ALUresult_MEM_WB),
        .i_in3 (32'd0),
        .i_sel (ForwardA),
        .o_out (w_op_a)
    );

    // Forwarding on B sits after the immediate select, so it overrides imm.
    MUX4x1 u_fwd_b (
        .i_in0 (w_operand2),
        .i_in1 (ALUresult_EXE_MEM),
        .i_in2 (ALUresult_MEM_WB),
        .i_in3 (32'd0),
        .i_sel (ForwardB),
        .o_out (w_op_b)
    );

    ALU u_alu (
        .i_a      (w_op_a),
        .i_b      (w_op_b),
        .i_op     (ALUOp),
        .o_result (ALUresult),
        .o_zero   (w_zero_unused)
    );

    // Store data is the raw register value, never the forwarded or immediate operand.
    assign WriteData_MEM      = readData2;
    assign pc_MEM             = pc;
    assign RegDestination_MEM = RegDestination;
    assign MemtoReg_MEM       = MemtoReg;
    assign WordOrByte_MEM     = WordOrByte;
    assign MemRead_MEM        = MemRead;
    assign MemWrite_MEM       = MemWrite;
    assign RegWrite_MEM       = RegWrite;
endmodule

// File: tb/tb_exe_stage_unit.sv
// Bench for exe_stage_unit: directed cases plus randomized transactions checked
// through an expected-value queue popped by an independent monitor.

module tb_exe_stage_unit;
  localparam int W = 107;

  logic        clk;
  logic        reset_n;
  logic [1:0]  ForwardA, ForwardB;
  logic [31:0] ALUresult_EXE_MEM, ALUresult_MEM_WB;
  logic [31:0] readData1, readData2, imm, pc;
  logic [4:0]  RegDestination;
  logic [1:0]  MemtoReg;
  logic [3:0]  ALUOp;
  logic        WordOrByte, MemRead, MemWrite, ALUSrc, RegWrite;
  logic [31:0] ALUresult, pc_MEM, WriteData_MEM;
  logic [4:0]  RegDestination_MEM;
  logic [1:0]  MemtoReg_MEM;
  logic        WordOrByte_MEM, MemRead_MEM, MemWrite_MEM, RegWrite_MEM;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  bit           drv_done = 0;

  exe_stage_unit dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .ForwardA           (ForwardA),
    .ForwardB           (ForwardB),
    .ALUresult_EXE_MEM  (ALUresult_EXE_MEM),
    .ALUresult_MEM_WB   (ALUresult_MEM_WB),
    .readData1          (readData1),
    .readData2          (readData2),
    .imm                (imm),
    .RegDestination     (RegDestination),
    .pc                 (pc),
    .MemtoReg           (MemtoReg),
    .ALUOp              (ALUOp),
    .WordOrByte         (WordOrByte),
    .MemRead            (MemRead),
    .MemWrite           (MemWrite),
    .ALUSrc             (ALUSrc),
    .RegWrite           (RegWrite),
    .ALUresult          (ALUresult),
    .pc_MEM             (pc_MEM),
    .WriteData_MEM      (WriteData_MEM),
    .RegDestination_MEM (RegDestination_MEM),
    .MemtoReg_MEM       (MemtoReg_MEM),
    .WordOrByte_MEM     (WordOrByte_MEM),
    .MemRead_MEM        (MemRead_MEM),
    .MemWrite_MEM       (MemWrite_MEM),
    .RegWrite_MEM       (RegWrite_MEM)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: operand choice from the forwarding table, then the operation
  function automatic logic [31:0] ref_result();
    logic [31:0] src_a[4];
    logic [31:0] src_b[4];
    logic [31:0] a, b;
    logic [63:0] ext;
    int unsigned s;
    src_a = '{readData1, ALUresult_EXE_MEM, ALUresult_MEM_WB, 32'd0};
    src_b = '{(ALUSrc ? imm : readData2), ALUresult_EXE_MEM, ALUresult_MEM_WB, 32'd0};
    a = src_a[ForwardA];
    b = src_b[ForwardB];
    s = b % 32;
    ext = {{32{a[31]}}, a};
    case (ALUOp)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return 32'(64'(a) * (64'd1 << s));
      4'd5:    return 32'(64'(a) / (64'd1 << s));
      4'd6:    return a - b;
      4'd7:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd8:    return 32'(ext >> s);
      4'd9:    return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // driver tasks: inputs are already set right after a posedge; record expectation, hold one cycle
  task automatic issue(input string name, input logic [31:0] exp_alu);
    exp_q.push_back({exp_alu, pc, readData2, RegDestination, MemtoReg,
                     WordOrByte, MemRead, MemWrite, RegWrite});
    name_q.push_back(name);
    @(posedge clk);
  endtask

  task automatic set_ctrl(input logic [1:0] fa, input logic [1:0] fb, input logic src,
                          input logic [3:0] op);
    ForwardA = fa;
    ForwardB = fb;
    ALUSrc   = src;
    ALUOp    = op;
  endtask

  // scoreboard monitor: compares mid-cycle whenever an expectation is outstanding
  initial begin
    logic [W-1:0] act, exp_v;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm = name_q.pop_front();
        act = {ALUresult, pc_MEM, WriteData_MEM, RegDestination_MEM, MemtoReg_MEM,
               WordOrByte_MEM, MemRead_MEM, MemWrite_MEM, RegWrite_MEM};
        n_checks++;
        if (act !== exp_v) begin
          n_errors++;
          $display("FAIL %s: got alu=%h pc=%h wd=%h rest=%h, expected alu=%h pc=%h wd=%h rest=%h",
                   nm, act[106:75], act[74:43], act[42:11], act[10:0],
                   exp_v[106:75], exp_v[74:43], exp_v[42:11], exp_v[10:0]);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    reset_n = 1'b0;
    ForwardA = 2'b00; ForwardB = 2'b00;
    ALUresult_EXE_MEM = 32'd0; ALUresult_MEM_WB = 32'd0;
    readData1 = 32'd50; readData2 = 32'd20; imm = 32'd16;
    pc = 32'd8; RegDestination = 5'd2; MemtoReg = 2'b01;
    ALUOp = 4'b0110; WordOrByte = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
    ALUSrc = 1'b1; RegWrite = 1'b1;
    @(posedge clk);

    // outputs valid while reset is held
    issue("reset_sub_imm", 32'd34);
    reset_n = 1'b1;
    issue("after_reset_sub_imm", 32'd34);

    set_ctrl(2'b00, 2'b00, 1'b0, 4'b0010);
    issue("add_reg", 32'd70);
    readData1 = 32'd16; set_ctrl(2'b00, 2'b00, 1'b0, 4'b0110);
    issue("sub_negative", 32'hFFFF_FFFC);

    ALUresult_EXE_MEM = 32'd100; ALUresult_MEM_WB = 32'd7; imm = 32'd16;
    set_ctrl(2'b01, 2'b10, 1'b1, 4'b0010);
    issue("fwd_over_imm", 32'd107);

    readData1 = 32'h0F; set_ctrl(2'b00, 2'b11, 1'b0, 4'b0001);
    issue("fwdb_zero_or", 32'h0F);
    readData2 = 32'h1234; set_ctrl(2'b11, 2'b00, 1'b0, 4'b0010);
    issue("fwda_zero_add", 32'h1234);

    readData1 = 32'hFFFF_FFFF; readData2 = 32'd1; set_ctrl(2'b00, 2'b00, 1'b0, 4'b0111);
    issue("slt_signed", 32'd1);
    ALUOp = 4'b1001;
    issue("sltu", 32'd0);
    readData1 = 32'h8000_0000; readData2 = 32'd4; ALUOp = 4'b1000;
    issue("sra", 32'hF800_0000);
    ALUOp = 4'b0101;
    issue("srl", 32'h0800_0000);
    ALUOp = 4'b0100;
    issue("sll", 32'h0000_0000);
    readData1 = 32'h0000_00F3; readData2 = 32'h0000_0F0F; ALUOp = 4'b0000;
    issue("and", 32'h0000_0003);
    ALUOp = 4'b0011;
    issue("xor", 32'h0000_0FFC);
    ALUOp = 4'b1111;
    issue("illegal_op", 32'd0);

    // inputs held constant while reset toggles across clock edges
    for (int i = 0; i < 4; i++) begin
      reset_n = i[0];
      issue("reset_toggle_hold", 32'd0);
    end
    reset_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      reset_n = ($urandom_range(0, 9) != 0);
      ForwardA = 2'($urandom_range(0, 3));
      ForwardB = 2'($urandom_range(0, 3));
      ALUSrc = 1'($urandom_range(0, 1));
      ALUOp = 4'($urandom_range(0, 15));
      ALUresult_EXE_MEM = $urandom;
      ALUresult_MEM_WB = $urandom;
      readData1 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
      readData2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      pc = $urandom;
      RegDestination = 5'($urandom_range(0, 31));
      MemtoReg = 2'($urandom_range(0, 3));
      WordOrByte = 1'($urandom_range(0, 1));
      MemRead = 1'($urandom_range(0, 1));
      MemWrite = 1'($urandom_range(0, 1));
      RegWrite = 1'($urandom_range(0, 1));
      issue("random", ref_result());
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 100) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d expectations left, expected 0", exp_q.size());
    end
    drv_done = 1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
